// File: rtl/isr_shifter_if.sv
// Bundle between the PIO sequencer, the input shift register and the RX FIFO write port.
// The master drives the operation decode and FIFO status; the slave returns data, count and stall.
interface isr_shifter_if;
    logic        penable;
    logic [31:0] in_data;
    logic [4:0]  bit_count;
    logic        dir;
    logic        do_in;
    logic        do_push;
    logic        push_block;
    logic        push_iffull;
    logic        set;
    logic [31:0] set_data;
    logic        autopush;
    logic [4:0]  threshold;
    logic        rx_full;
    logic        push_valid;
    logic [31:0] push_data;
    logic        stall;
    logic [31:0] dout;
    logic [5:0]  shift_count;

    modport master (
        output penable, in_data, bit_count, dir, do_in, do_push, push_block,
               push_iffull, set, set_data, autopush, threshold, rx_full,
        input  push_valid, push_data, stall, dout, shift_count
    );

    modport slave (
        input  penable, in_data, bit_count, dir, do_in, do_push, push_block,
               push_iffull, set, set_data, autopush, threshold, rx_full,
        output push_valid, push_data, stall, dout, shift_count
    );
endinterface

// File: rtl/isr_shifter.sv
// PIO input shift register: accumulates 1..32 bits per IN, tracks a saturating count,
// and writes completed words to the RX FIFO by explicit PUSH or autopush.
module isr_shifter (
    input  logic          clk,
    input  logic          reset,
    isr_shifter_if.slave  bus
);
    logic [31:0] isr;
    logic [5:0]  count;
    logic [5:0]  n;
    logic [5:0]  thresh;
    logic [31:0] in_mask;
    logic [31:0] in_bits;
    logic [31:0] shifted;
    logic [6:0]  count_sum;
    logic [5:0]  count_next;
    logic        reached;
    logic        push_go;
    logic        push_stall;
    logic        auto_stall;

    // A field value of 0 stands for a full 32-bit word.
    assign n      = (bus.bit_count == 5'd0) ? 6'd32 : {1'b0, bus.bit_count};
    assign thresh = (bus.threshold == 5'd0) ? 6'd32 : {1'b0, bus.threshold};

    // Shifting by 32 yields zero, so n = 32 collapses to isr' = in_data in both directions.
    assign in_mask = (n == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    assign in_bits = bus.in_data & in_mask;
    assign shifted = bus.dir ? ((isr >> n) | (in_bits << (6'd32 - n)))
                             : ((isr << n) | in_bits);

    assign count_sum  = {1'b0, count} + {1'b0, n};
    assign count_next = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];
    assign reached    = (count_next >= thresh);

    assign push_go    = !(bus.push_iffull && (count < thresh));
    assign push_stall = !bus.set && bus.do_push && push_go && bus.rx_full && bus.push_block;
    assign auto_stall = !bus.set && !bus.do_push && bus.do_in && bus.autopush
                        && reached && bus.rx_full;

    assign bus.stall       = bus.penable && reset && (push_stall || auto_stall);
    assign bus.dout        = isr;
    assign bus.shift_count = count;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            isr            <= '0;
            count          <= '0;
            bus.push_valid <= 1'b0;
            bus.push_data  <= '0;
        end else begin
            bus.push_valid <= 1'b0;
            if (bus.penable) begin
                if (bus.set) begin
                    isr   <= bus.set_data;
                    count <= '0;
                end else if (bus.do_push) begin
                    if (push_go) begin
                        if (!bus.rx_full) begin
                            bus.push_data  <= isr;
                            bus.push_valid <= 1'b1;
                            isr            <= '0;
                            count          <= '0;
                        end else if (!bus.push_block) begin
                            isr   <= '0;
                            count <= '0;
                        end
                    end
                end else if (bus.do_in) begin
                    if (bus.autopush && reached) begin
                        if (!bus.rx_full) begin
                            bus.push_data  <= shifted;
                            bus.push_valid <= 1'b1;
                            isr            <= '0;
                            count          <= '0;
                        end
                    end else begin
                        isr   <= shifted;
                        count <= count_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_isr_shifter.sv
// Directed self-checking bench for isr_shifter: shifting, saturation, set, autopush,
// explicit push variants, mid-operation reset and clock-enable hold.
module tb_isr_shifter;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    isr_shifter_if bus ();

    isr_shifter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ops();
        bus.do_in       = 1'b0;
        bus.do_push     = 1'b0;
        bus.set         = 1'b0;
        bus.push_block  = 1'b0;
        bus.push_iffull = 1'b0;
        bus.rx_full     = 1'b0;
    endtask

    task automatic load(input logic [31:0] value);
        idle_ops();
        bus.set      = 1'b1;
        bus.set_data = value;
        step();
        bus.set = 1'b0;
    endtask

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.penable = 1'b1; bus.do_in = 1'b1; bus.autopush = 1'b1; bus.rx_full = 1'b1;
        bus.threshold = 5'd1; bus.bit_count = 5'd1;
        #3;
        cmp32("reset_dout", bus.dout, 32'h0);
        cmp32("reset_count", {26'd0, bus.shift_count}, 32'd0);
        cmp32("reset_push_valid", {31'd0, bus.push_valid}, 32'd0);
        cmp32("reset_push_data", bus.push_data, 32'h0);
        cmp32("reset_stall", {31'd0, bus.stall}, 32'd0);
        idle_ops();
        bus.autopush = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_shift_left();
        idle_ops();
        bus.dir = 1'b0; bus.bit_count = 5'd8; bus.in_data = 32'h0000_00A5; bus.do_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        cmp32("left_dout", bus.dout, 32'hA5A5_A5A5);
        cmp32("left_count", {26'd0, bus.shift_count}, 32'd32);
        cmp32("left_no_push", {31'd0, bus.push_valid}, 32'd0);
        step();
        cmp32("left_sat_count", {26'd0, bus.shift_count}, 32'd32);
        cmp32("left_sat_dout", bus.dout, 32'hA5A5_A5A5);
        bus.do_in = 1'b0;
    endtask

    task automatic test_shift_right();
        load(32'h0);
        bus.dir = 1'b1; bus.bit_count = 5'd4; bus.in_data = 32'hFFFF_FFFF; bus.do_in = 1'b1;
        step();
        cmp32("right_first", bus.dout, 32'hF000_0000);
        step();
        cmp32("right_dout", bus.dout, 32'hFF00_0000);
        cmp32("right_count", {26'd0, bus.shift_count}, 32'd8);
        load(32'h1234_5678);
        cmp32("set_dout", bus.dout, 32'h1234_5678);
        cmp32("set_count", {26'd0, bus.shift_count}, 32'd0);
        bus.bit_count = 5'd0; bus.in_data = 32'hCAFE_F00D; bus.do_in = 1'b1;
        step();
        cmp32("full_word_dout", bus.dout, 32'hCAFE_F00D);
        cmp32("full_word_count", {26'd0, bus.shift_count}, 32'd32);
        bus.do_in = 1'b0;
    endtask

    task automatic test_autopush();
        load(32'h0);
        bus.autopush = 1'b1; bus.threshold = 5'd8;
        bus.dir = 1'b0; bus.bit_count = 5'd8; bus.in_data = 32'h0000_003C; bus.do_in = 1'b1;
        step();
        bus.do_in = 1'b0;
        cmp32("auto_valid", {31'd0, bus.push_valid}, 32'd1);
        cmp32("auto_data", bus.push_data, 32'h0000_003C);
        cmp32("auto_dout", bus.dout, 32'h0);
        cmp32("auto_count", {26'd0, bus.shift_count}, 32'd0);
        step();
        cmp32("auto_one_pulse", {31'd0, bus.push_valid}, 32'd0);
    endtask

    task automatic test_autopush_stall();
        int pushes;
        bus.do_in = 1'b1; bus.rx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp32("stall_high", {31'd0, bus.stall}, 32'd1);
            step();
            cmp32("stall_dout", bus.dout, 32'h0);
            cmp32("stall_count", {26'd0, bus.shift_count}, 32'd0);
            cmp32("stall_no_push", {31'd0, bus.push_valid}, 32'd0);
        end
        bus.rx_full = 1'b0;
        #1;
        cmp32("stall_released", {31'd0, bus.stall}, 32'd0);
        step();
        bus.do_in = 1'b0;
        cmp32("stall_push_data", bus.push_data, 32'h0000_003C);
        pushes = int'(bus.push_valid);
        for (int i = 0; i < 3; i++) begin
            step();
            pushes += int'(bus.push_valid);
        end
        cmp32("stall_single_push", pushes, 32'd1);
        bus.autopush = 1'b0;
    endtask

    task automatic test_explicit_push();
        load(32'hDEAD_BEEF);
        bus.do_push = 1'b1; bus.rx_full = 1'b1; bus.push_block = 1'b0;
        #1;
        cmp32("drop_no_stall", {31'd0, bus.stall}, 32'd0);
        step();
        cmp32("drop_no_valid", {31'd0, bus.push_valid}, 32'd0);
        cmp32("drop_dout", bus.dout, 32'h0);
        load(32'h0);
        bus.dir = 1'b0; bus.bit_count = 5'd4; bus.in_data = 32'h0000_0009; bus.do_in = 1'b1;
        step();
        bus.do_in = 1'b0;
        cmp32("iffull_setup", {26'd0, bus.shift_count}, 32'd4);
        bus.threshold = 5'd16; bus.push_iffull = 1'b1; bus.do_push = 1'b1;
        step();
        cmp32("iffull_no_valid", {31'd0, bus.push_valid}, 32'd0);
        cmp32("iffull_dout", bus.dout, 32'h0000_0009);
        cmp32("iffull_count", {26'd0, bus.shift_count}, 32'd4);
        bus.push_iffull = 1'b0;
        step();
        bus.do_push = 1'b0;
        cmp32("push_valid", {31'd0, bus.push_valid}, 32'd1);
        cmp32("push_data", bus.push_data, 32'h0000_0009);
        cmp32("push_clears", bus.dout, 32'h0);
        load(32'h0000_ABCD);
        bus.do_push = 1'b1; bus.rx_full = 1'b1; bus.push_block = 1'b1;
        #1;
        cmp32("block_stall", {31'd0, bus.stall}, 32'd1);
        step();
        cmp32("block_hold", bus.dout, 32'h0000_ABCD);
        cmp32("block_no_valid", {31'd0, bus.push_valid}, 32'd0);
        idle_ops();
    endtask

    task automatic test_reset_mid_op();
        load(32'h0000_0077);
        bus.do_push = 1'b1;
        step();
        bus.do_push = 1'b0;
        cmp32("pre_reset_valid", {31'd0, bus.push_valid}, 32'd1);
        bus.autopush = 1'b1; bus.threshold = 5'd8; bus.bit_count = 5'd8;
        bus.do_in = 1'b1; bus.rx_full = 1'b1;
        #1;
        cmp32("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
        reset = 1'b0;
        #1;
        cmp32("mid_reset_valid", {31'd0, bus.push_valid}, 32'd0);
        cmp32("mid_reset_data", bus.push_data, 32'h0);
        cmp32("mid_reset_stall", {31'd0, bus.stall}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.penable = ~bus.penable;
            step();
        end
        cmp32("mid_reset_dout", bus.dout, 32'h0);
        bus.penable = 1'b1;
        idle_ops();
        bus.autopush = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_penable_hold();
        load(32'h0000_005A);
        bus.penable = 1'b0;
        bus.do_push = 1'b1; bus.rx_full = 1'b1; bus.push_block = 1'b1;
        bus.do_in = 1'b1; bus.bit_count = 5'd8;
        #1;
        cmp32("hold_stall", {31'd0, bus.stall}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        cmp32("hold_dout", bus.dout, 32'h0000_005A);
        cmp32("hold_count", {26'd0, bus.shift_count}, 32'd0);
        cmp32("hold_no_valid", {31'd0, bus.push_valid}, 32'd0);
        bus.penable = 1'b1;
        idle_ops();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        idle_ops();
        bus.penable = 1'b1; bus.dir = 1'b0; bus.in_data = '0; bus.bit_count = '0;
        bus.set_data = '0; bus.autopush = 1'b0; bus.threshold = '0;
        test_reset();
        test_shift_left();
        test_shift_right();
        test_autopush();
        test_autopush_stall();
        test_explicit_push();
        test_reset_mid_op();
        test_penable_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
